cpu_bus_ctrl: RTL

Bus controller between the `Cpu` core and external memory. It accepts the core's `req_rdwr`/`which_rdwr`/`addr`/`data_out` requests and runs each one as a handshaked access with wait states and a timeout on the memory side. It stalls the core through the core's `enable` input until read data is valid on `data_in`, so the core's one-cycle load/store states work unchanged against slow memory.

---
 rtl/cpu_bus_ctrl_pkg.sv | 18 +
 rtl/cpu_bus_wait_ctr.sv | 43 ++++
 rtl/cpu_bus_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/cpu_bus_ctrl_pkg.sv
// Shared types for the core-to-memory bus controller: controller states and
// the core's read/write direction encoding.
package cpu_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        BUS_ST_IDLE   = 2'd0,
        BUS_ST_ACCESS = 2'd1,
        BUS_ST_DONE   = 2'd2
    } bus_state_e;

    localparam logic ENUM__CPU_WH_RDWR__READ  = 1'b0;
    localparam logic ENUM__CPU_WH_RDWR__WRITE = 1'b1;

    function automatic logic is_write(input logic which_rdwr);
        return which_rdwr == ENUM__CPU_WH_RDWR__WRITE;
    endfunction

endpackage : cpu_bus_ctrl_pkg

// File: rtl/cpu_bus_wait_ctr.sv
// Saturating ACCESS-cycle counter; flags the wait-state threshold and the
// timeout point for the bus controller.
module cpu_bus_wait_ctr #(
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic reached_wait,
    output logic reached_timeout
);

    localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W:0]   cnt_p1;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CNT_W'(TIMEOUT))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt >= WAIT_STATES written as cnt+1 > WAIT_STATES so WAIT_STATES=0 stays a live compare
    assign cnt_p1          = {1'b0, cnt_q} + (CNT_W + 1)'(1);
    assign reached_wait    = cnt_p1 > (CNT_W + 1)'(WAIT_STATES);
    assign reached_timeout = cnt_q == CNT_W'(TIMEOUT);

endmodule : cpu_bus_wait_ctr

// File: rtl/cpu_bus_ctrl.sv
// Bus controller: runs each core load/store as one handshaked memory access
// with wait states and timeout, stalling the core until the access is done.
module cpu_bus_ctrl
    import cpu_bus_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req_rdwr,
    input  logic                  cpu_which_rdwr,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_data_out,
    output logic [DATA_WIDTH-1:0] cpu_data_in,
    output logic                  cpu_enable,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  bus_err
);

    bus_state_e state_q;
    bus_state_e state_d;

    logic                  mem_req_q,   mem_req_d;
    logic                  mem_we_q,    mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0] data_in_q,   data_in_d;
    logic                  bus_err_q,   bus_err_d;

    logic ctr_clr;
    logic ctr_en;
    logic reached_wait;
    logic reached_timeout;
    logic complete;
    logic timed_out;

    cpu_bus_wait_ctr #(
        .WAIT_STATES (WAIT_STATES),
        .TIMEOUT     (TIMEOUT)
    ) u_wait_ctr (
        .clk             (clk),
        .rst             (rst),
        .clr             (ctr_clr),
        .en              (ctr_en),
        .reached_wait    (reached_wait),
        .reached_timeout (reached_timeout)
    );

    // Completion has priority over timeout in the same cycle
    assign complete  = (state_q == BUS_ST_ACCESS) && reached_wait && mem_ack;
    assign timed_out = (state_q == BUS_ST_ACCESS) && reached_timeout && !complete;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BUS_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BUS_ST_IDLE:   if (cpu_req_rdwr) state_d = BUS_ST_ACCESS;
            BUS_ST_ACCESS: if (complete || timed_out) state_d = BUS_ST_DONE;
            BUS_ST_DONE:   state_d = BUS_ST_IDLE;
            default:       state_d = BUS_ST_IDLE;
        endcase
    end

    always_comb begin
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        data_in_d   = data_in_q;
        bus_err_d   = bus_err_q;
        ctr_clr     = 1'b0;
        ctr_en      = 1'b0;
        case (state_q)
            BUS_ST_IDLE: begin
                if (cpu_req_rdwr) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = is_write(cpu_which_rdwr);
                    mem_addr_d  = cpu_addr;
                    mem_wdata_d = cpu_data_out;
                    ctr_clr     = 1'b1;
                end
            end
            BUS_ST_ACCESS: begin
                ctr_en = 1'b1;
                if (complete) begin
                    mem_req_d = 1'b0;
                    if (!mem_we_q) data_in_d = mem_rdata;
                end else if (timed_out) begin
                    mem_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    if (!mem_we_q) data_in_d = '1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            data_in_q   <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            data_in_q   <= data_in_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign cpu_enable  = (state_q == BUS_ST_DONE) ||
                         ((state_q == BUS_ST_IDLE) && !cpu_req_rdwr);
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign cpu_data_in = data_in_q;
    assign bus_err     = bus_err_q;

endmodule : cpu_bus_ctrl
